// File: rtl/scoreboard_regfile_pkg.sv
// Shared CPU package: default register-file geometry and the address-width helper.
package scoreboard_regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;
    localparam int NWR_DEF  = 2;

    // Bits needed to index n items; never less than 1 so single-entry selects stay legal.
    function automatic int addr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scoreboard_regfile_wr_arbiter.sv
// Write-port priority resolver: for every register, reports whether any enabled
// write port targets it and which port wins (highest index wins). Register 0 is
// never reported as hit, so writes to it are dropped everywhere downstream.
module regfile_wr_arbiter
    import scoreboard_regfile_pkg::*;
#(
    parameter int  NREG = NREG_DEF,
    parameter int  NWR  = NWR_DEF,
    localparam int AW   = addr_width(NREG),
    localparam int PW   = addr_width(NWR)
) (
    input  logic [NWR-1:0]     enable,
    input  logic [NWR*AW-1:0]  addr,
    output logic [NREG-1:0]    hit,
    output logic [NREG*PW-1:0] sel
);

    // Scan ports in ascending order so a later (higher) port overrides an earlier one.
    always_comb begin
        hit = '0;
        sel = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int p = 0; p < NWR; p++) begin
                if (enable[p] && (addr[p*AW +: AW] == AW'(r))) begin
                    hit[r]           = 1'b1;
                    sel[r*PW +: PW]  = PW'(p);
                end
            end
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-ported register file with a per-register scoreboard busy bit.
// Reads are combinational with write-through bypass; a register is marked busy
// when an instruction targeting it issues and cleared when a write lands, with a
// same-cycle issue taking precedence over the write (the new producer wins).
module scoreboard_regfile
    import scoreboard_regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRD  = NRD_DEF,
    parameter int  NWR  = NWR_DEF,
    localparam int AW   = addr_width(NREG),
    localparam int PW   = addr_width(NWR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ReadRegister,
    output logic [NRD*XLEN-1:0] ReadData,
    output logic [NRD-1:0]      ReadBusy,
    input  logic [NWR-1:0]      WriteEnable,
    input  logic [NWR*AW-1:0]   WriteRegister,
    input  logic [NWR*XLEN-1:0] WriteData,
    input  logic                IssueValid,
    input  logic [AW-1:0]       IssueRegister,
    output logic [NREG-1:0]     BusyVec
);

    logic [XLEN-1:0]    regs    [NREG];
    logic [XLEN-1:0]    wr_data [NREG];
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    wr_hit;
    logic [NREG*PW-1:0] wr_sel;
    logic [NREG-1:0]    issue_mask;
    logic [AW-1:0]      rd_addr [NRD];

    regfile_wr_arbiter #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_wr_arbiter (
        .enable (WriteEnable),
        .addr   (WriteRegister),
        .hit    (wr_hit),
        .sel    (wr_sel)
    );

    // Winning write data per register, steered by the arbiter's port select.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_data[r] = '0;
            wr_data[r] = WriteData[int'(wr_sel[r*PW +: PW])*XLEN +: XLEN];
        end
    end

    // One-hot of the issued destination; register 0 never becomes busy.
    always_comb begin
        issue_mask = '0;
        if (IssueValid && (IssueRegister != '0)) begin
            issue_mask[IssueRegister] = 1'b1;
        end
    end

    // Register storage in flops so reset can clear every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_data[r];
                end
            end
        end
    end

    // Scoreboard: a write retires the producer, but a same-cycle issue re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= issue_mask | (busy & ~wr_hit);
        end
    end

    // Combinational read ports with write-through bypass and busy forwarding.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_addr[i] = ReadRegister[i*AW +: AW];
            if (rd_addr[i] != '0) begin
                if (wr_hit[rd_addr[i]]) begin
                    ReadData[i*XLEN +: XLEN] = wr_data[rd_addr[i]];
                end else begin
                    ReadData[i*XLEN +: XLEN] = regs[rd_addr[i]];
                end
            end
            ReadBusy[i] = busy[rd_addr[i]] & ~(wr_hit[rd_addr[i]] & ~issue_mask[rd_addr[i]]);
        end
    end

    // Registered busy state only; no same-cycle forwarding here.
    assign BusyVec = busy;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Directed bench for scoreboard_regfile: default 2R/2W instance plus a 3R/1W 64-bit instance.
`timescale 1ns/1ps
module tb_scoreboard_regfile;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default instance (XLEN=32, NREG=32, NRD=2, NWR=2) ----------------
    logic [9:0]  rr;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [1:0]  we;
    logic [9:0]  wr;
    logic [63:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [31:0] bv;

    scoreboard_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ReadRegister  (rr),
        .ReadData      (rd),
        .ReadBusy      (rbusy),
        .WriteEnable   (we),
        .WriteRegister (wr),
        .WriteData     (wd),
        .IssueValid    (iv),
        .IssueRegister (ir),
        .BusyVec       (bv)
    );

    // ---------------- wide instance (XLEN=64, NRD=3, NWR=1) ----------------
    logic [14:0]  b_rr;
    logic [191:0] b_rd;
    logic [2:0]   b_rbusy;
    logic [0:0]   b_we;
    logic [4:0]   b_wr;
    logic [63:0]  b_wd;
    logic         b_iv;
    logic [4:0]   b_ir;
    logic [31:0]  b_bv;

    scoreboard_regfile #(
        .XLEN (64),
        .NREG (32),
        .NRD  (3),
        .NWR  (1)
    ) dut_wide (
        .clk           (clk),
        .rst_n         (rst_n),
        .ReadRegister  (b_rr),
        .ReadData      (b_rd),
        .ReadBusy      (b_rbusy),
        .WriteEnable   (b_we),
        .WriteRegister (b_wr),
        .WriteData     (b_wd),
        .IssueValid    (b_iv),
        .IssueRegister (b_ir),
        .BusyVec       (b_bv)
    );

    // ---------------- scoreboard / checking ----------------
    int total;
    int bad;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        we = '0; wr = '0; wd = '0; iv = 1'b0; ir = '0; rr = '0;
        b_we = '0; b_wr = '0; b_wd = '0; b_iv = 1'b0; b_ir = '0; b_rr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input int port, input int r);
        rr[port*5 +: 5] = 5'(r);
    endtask

    task automatic set_write(input int port, input int r, input logic [31:0] d);
        we[port]         = 1'b1;
        wr[port*5 +: 5]  = 5'(r);
        wd[port*32 +: 32] = d;
    endtask

    task automatic issue(input int r);
        iv = 1'b1;
        ir = 5'(r);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle();
        #2;
        // reset state
        check_val("reset_busyvec", 64'(bv), 64'h0);
        set_read(0, 5);
        #1;
        check_val("reset_read_x5", 64'(rd[31:0]), 64'h0);
        tick();
        rst_n = 1'b1;
        idle();
        #1;

        // issue x5; BusyVec is registered so no change until the edge
        issue(5);
        #1;
        check_val("issue_pre_edge_busyvec", 64'(bv), 64'h0);
        tick();
        idle();
        set_read(0, 5);
        #1;
        check_val("issue_readbusy", 64'(rbusy[0]), 64'h1);
        check_val("issue_busyvec", 64'(bv), 64'h0000_0020);
        check_val("issue_readdata", 64'(rd[31:0]), 64'h0);

        // two ports write x5 same cycle; port 1 wins, bypass shows it
        set_write(0, 5, 32'h11);
        set_write(1, 5, 32'h22);
        #1;
        check_val("dual_write_bypass", 64'(rd[31:0]), 64'h22);
        check_val("dual_write_readbusy", 64'(rbusy[0]), 64'h0);
        check_val("dual_write_busyvec_pre", 64'(bv), 64'h0000_0020);
        tick();
        idle();
        set_read(0, 5);
        #1;
        check_val("dual_write_stored", 64'(rd[31:0]), 64'h22);
        check_val("dual_write_busy_clear", 64'(bv), 64'h0);

        // x0 is hardwired: write and issue both ignored
        set_write(0, 0, 32'hDEAD_BEEF);
        issue(0);
        set_read(0, 0);
        #1;
        check_val("x0_bypass_zero", 64'(rd[31:0]), 64'h0);
        check_val("x0_readbusy", 64'(rbusy[0]), 64'h0);
        tick();
        idle();
        set_read(0, 0);
        #1;
        check_val("x0_read_zero", 64'(rd[31:0]), 64'h0);
        check_val("x0_busyvec", 64'(bv), 64'h0);

        // busy x7, then same-cycle issue + write on x7: producer re-arms
        issue(7);
        tick();
        idle();
        #1;
        check_val("x7_busy_set", 64'(bv), 64'h0000_0080);
        issue(7);
        set_write(0, 7, 32'h33);
        set_read(1, 7);
        #1;
        check_val("x7_same_cycle_readbusy", 64'(rbusy[1]), 64'h1);
        check_val("x7_same_cycle_bypass", 64'(rd[63:32]), 64'h33);
        tick();
        idle();
        set_read(1, 7);
        #1;
        check_val("x7_data_after", 64'(rd[63:32]), 64'h33);
        check_val("x7_busy_kept", 64'(bv), 64'h0000_0080);
        check_val("x7_readbusy_after", 64'(rbusy[1]), 64'h1);

        // write x7 from port 1 clears busy; ReadBusy drops in the same cycle
        set_write(1, 7, 32'h34);
        set_read(0, 7);
        #1;
        check_val("x7_clear_readbusy", 64'(rbusy[0]), 64'h0);
        check_val("x7_clear_busyvec_pre", 64'(bv), 64'h0000_0080);
        tick();
        idle();
        #1;
        check_val("x7_clear_busyvec", 64'(bv), 64'h0);

        // non-busy write to x3, and two different-address writes with bypass on both ports
        set_write(0, 3, 32'h44);
        tick();
        idle();
        set_read(0, 3);
        #1;
        check_val("nonbusy_write_data", 64'(rd[31:0]), 64'h44);
        check_val("nonbusy_write_busy", 64'(bv), 64'h0);
        set_write(0, 9, 32'h55);
        set_write(1, 10, 32'h66);
        set_read(0, 10);
        set_read(1, 9);
        #1;
        check_val("split_bypass_p0", 64'(rd[31:0]), 64'h66);
        check_val("split_bypass_p1", 64'(rd[63:32]), 64'h55);

        // load x1..x31 with distinct values, two per cycle, and leave x4 busy
        idle();
        for (int r = 1; r < 32; r += 2) begin
            idle();
            set_write(0, r, 32'h1000 + 32'(r));
            if (r + 1 < 32) set_write(1, r + 1, 32'h1000 + 32'(r + 1));
            tick();
        end
        idle();
        issue(4);
        tick();
        idle();
        set_read(0, 31);
        set_read(1, 1);
        #1;
        check_val("load_x31", 64'(rd[31:0]), 64'h101F);
        check_val("load_x1", 64'(rd[63:32]), 64'h1001);
        check_val("load_busy_x4", 64'(bv), 64'h0000_0010);

        // async reset pulse between edges clears everything before the next edge
        #1;
        rst_n = 1'b0;
        #0.2;
        check_val("async_rst_busyvec", 64'(bv), 64'h0);
        for (int r = 1; r < 32; r++) begin
            set_read(0, r);
            #0.2;
            check_val($sformatf("async_rst_x%0d", r), 64'(rd[31:0]), 64'h0);
        end
        // writes during reset are bypassed but not stored
        set_write(0, 8, 32'h99);
        issue(8);
        set_read(1, 8);
        #0.2;
        check_val("rst_write_bypass", 64'(rd[63:32]), 64'h99);
        tick();
        check_val("rst_issue_ignored", 64'(bv), 64'h0);
        idle();
        set_read(1, 8);
        #1;
        check_val("rst_write_dropped", 64'(rd[63:32]), 64'h0);
        rst_n = 1'b1;
        #1;

        // first edge after release behaves normally
        set_write(0, 2, 32'h77);
        issue(6);
        tick();
        idle();
        set_read(0, 2);
        #1;
        check_val("post_rst_write", 64'(rd[31:0]), 64'h77);
        check_val("post_rst_issue", 64'(bv), 64'h0000_0040);

        // wide instance: write x31 then read it on all three ports
        b_we = 1'b1;
        b_wr = 5'd31;
        b_wd = 64'hFFFF_FFFF_0000_0001;
        b_rr = {5'd31, 5'd31, 5'd31};
        #1;
        check_val("wide_bypass_p2", b_rd[191:128], 64'hFFFF_FFFF_0000_0001);
        tick();
        b_we = '0;
        b_wd = '0;
        #1;
        check_val("wide_p0", b_rd[63:0], 64'hFFFF_FFFF_0000_0001);
        check_val("wide_p1", b_rd[127:64], 64'hFFFF_FFFF_0000_0001);
        check_val("wide_p2", b_rd[191:128], 64'hFFFF_FFFF_0000_0001);
        check_val("wide_busyvec", 64'(b_bv), 64'h0);
        check_val("wide_readbusy", 64'(b_rbusy), 64'h0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, read-port count (>=1).
REQ-004 SHALL have parameter NWR, default 2, write-port count (>=1).
REQ-005 SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 ReadRegister  input  NRD*AW  packed read addresses; port i at [i*AW +: AW].
REQ-009 ReadData  output  NRD*XLEN  packed read data.
REQ-010 ReadBusy  output  NRD  per-read-port pending-write flag.
REQ-011 WriteEnable  input  NWR  per-write-port enable.
REQ-012 WriteRegister  input  NWR*AW  packed write addresses.
REQ-013 WriteData  input  NWR*XLEN  packed write data.
REQ-014 IssueValid  input  1  marks IssueRegister as having an in-flight producer.
REQ-015 IssueRegister  input  AW  destination of issued instruction.
REQ-016 BusyVec  output  NREG  busy bit per register.

Function
REQ-017 Register 0 SHALL always read 0, SHALL never be busy; writes and issues to 0 SHALL be ignored.
REQ-018 On a rising clk, each port with WriteEnable=1 and nonzero address SHALL update that register.
REQ-019 Same-cycle writes to one address SHALL resolve to the highest-indexed write port.
REQ-020 Reads SHALL be combinational, zero latency.
REQ-021 A read matching an enabled write in the same cycle SHALL return that WriteData (write-through bypass), using REQ-019 priority.
REQ-022 Busy bit r SHALL set at the next edge when IssueValid=1 and IssueRegister=r (r!=0).
REQ-023 Busy bit r SHALL clear at the next edge when any enabled write targets r.
REQ-024 Same-cycle issue and write to the same r SHALL leave busy set (new producer wins).
REQ-025 ReadBusy[i] SHALL equal busy bit of ReadRegister[i], forced 0 when that register is written this cycle and not simultaneously issued.
REQ-026 A write to a non-busy register SHALL still update data; busy stays 0.
REQ-027 BusyVec SHALL reflect registered busy state only (no bypass).

Reset
REQ-028 rst_n low SHALL immediately clear all registers to 0 and all busy bits to 0, independent of clk.
REQ-029 During reset, writes and issues SHALL be ignored; ReadData SHALL read 0 except where REQ-021 bypass applies.
REQ-030 Reset asserted mid-operation SHALL discard all pending busy state; first edge after release SHALL operate normally.

Structure
REQ-031 Defaults for XLEN/NREG/NRD/NWR and the AW derivation function SHALL live in the shared CPU package.
REQ-032 Write-port priority resolution SHALL be a sub-module regfile_wr_arbiter (per-address winning port and hit flag).
REQ-033 Storage SHALL be flip-flops (async reset needs it), not inferred RAM.

Verification
REQ-034 Reset; issue x5; next cycle ReadRegister0=5 -> ReadBusy[0]=1, BusyVec[5]=1, ReadData=0.
REQ-035 Port0 writes x5=0x11, port1 writes x5=0x22 same cycle, read x5 same cycle -> 0x22; next cycle -> 0x22, busy[5]=0.
REQ-036 Write x0=0xDEADBEEF with IssueRegister=0 -> ReadData for x0 = 0, BusyVec[0]=0.
REQ-037 Busy x7; issue x7 and write x7=0x33 same cycle -> next cycle data 0x33, BusyVec[7]=1; same cycle ReadBusy=1.
REQ-038 Load x1..x31 with distinct values, pulse rst_n low between clk edges -> all reads 0 and BusyVec=0 before the next edge.
REQ-039 Parameterise NRD=3, NWR=1, XLEN=64: write x31=0xFFFF_FFFF_0000_0001, read on all three ports -> identical value.
